// File: rtl/seq_generator_moore.sv
// rtl/seq_generator_moore.sv - Moore-style p1/p2 symbol pattern transmitter (optional SEQGEN_LOOP_EN)
module seq_generator_moore #(
    parameter int LEN       = 4,
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LEN-1:0]             pattern,
`ifdef SEQGEN_LOOP_EN
    input  logic                       loop,
`endif
    output logic                       p1,
    output logic                       p2,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LEN+1)-1:0]   sym_idx
);

    localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int SW   = $clog2(LEN + 1);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    // GAP is never entered when GAP_CYC is 0, so its terminal count is a don't-care then.
    localparam logic [CW-1:0] GAP_LAST   = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
    localparam logic [SW-1:0] SYM_LAST   = SW'(LEN - 1);
    localparam logic [SW-1:0] SYM_ALL    = SW'(LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [LEN-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [SW-1:0]   sym_q,   sym_d;
    logic            p1_q,    p1_d;
    logic            p2_q,    p2_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
`ifdef SEQGEN_LOOP_EN
    logic [LEN-1:0]  pat_q,   pat_d;
`endif

    logic [LEN-1:0]  shifted;
    logic            last_sym;
    logic            slot_end;

    assign shifted  = shreg_q << 1;
    assign last_sym = (sym_q == SYM_LAST);

    // Next state and next registered outputs; outputs are decided together with the state
    // so that they change on the same edge and never glitch.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sym_d    = sym_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        slot_end = 1'b0;
`ifdef SEQGEN_LOOP_EN
        pat_d    = pat_q;
`endif
        case (state_q)
            S_IDLE: begin
                p1_d   = 1'b0;
                p2_d   = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    shreg_d = pattern;
                    cnt_d   = '0;
                    sym_d   = '0;
                    state_d = S_PULSE;
                    p1_d    = pattern[LEN-1];
                    p2_d    = ~pattern[LEN-1];
                    busy_d  = 1'b1;
`ifdef SEQGEN_LOOP_EN
                    pat_d   = pattern;
`endif
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                        p1_d    = 1'b0;
                        p2_d    = 1'b0;
                    end else begin
                        slot_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    slot_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                p1_d    = 1'b0;
                p2_d    = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                p1_d    = 1'b0;
                p2_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // A symbol slot just finished: advance to the next symbol, wrap, or finish.
        if (slot_end) begin
            cnt_d = '0;
            if (!last_sym) begin
                shreg_d = shifted;
                sym_d   = sym_q + SW'(1);
                state_d = S_PULSE;
                p1_d    = shifted[LEN-1];
                p2_d    = ~shifted[LEN-1];
                busy_d  = 1'b1;
            end
`ifdef SEQGEN_LOOP_EN
            else if (loop) begin
                // Replays the pattern captured at start, never the live input.
                shreg_d = pat_q;
                sym_d   = '0;
                state_d = S_PULSE;
                p1_d    = pat_q[LEN-1];
                p2_d    = ~pat_q[LEN-1];
                busy_d  = 1'b1;
                done_d  = 1'b1;
            end
`endif
            else begin
                shreg_d = shifted;
                sym_d   = SYM_ALL;
                state_d = S_DONE;
                p1_d    = 1'b0;
                p2_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sym_q   <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQGEN_LOOP_EN
            pat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQGEN_LOOP_EN
            pat_q   <= pat_d;
`endif
        end
    end

    assign p1      = p1_q;
    assign p2      = p2_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sym_idx = sym_q;

endmodule

// File: tb/tb_seq_generator_moore.sv
// tb/tb_seq_generator_moore.sv - randomized bench for seq_generator_moore against a timing-arithmetic model
module tb_seq_generator_moore;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
`ifdef SEQGEN_LOOP_EN
    logic       loop_in = 1'b0;
`endif

    logic       a_p1, a_p2, a_busy, a_done;
    logic       b_p1, b_p2, b_busy, b_done;
    logic       c_p1, c_p2, c_busy, c_done;
    logic [2:0] a_sym, b_sym, c_sym;

    logic [6:0] obs [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         act [3];
    int         t0  [3];
    logic [3:0] pat [3];
    int         pc  [3];
    int         gc  [3];

    always #5 clk = ~clk;

    seq_generator_moore #(.LEN(LEN), .PULSE_CYC(1), .GAP_CYC(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
`ifdef SEQGEN_LOOP_EN
        .loop(loop_in),
`endif
        .p1(a_p1), .p2(a_p2), .busy(a_busy), .done(a_done), .sym_idx(a_sym)
    );

    seq_generator_moore #(.LEN(LEN), .PULSE_CYC(1), .GAP_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
`ifdef SEQGEN_LOOP_EN
        .loop(loop_in),
`endif
        .p1(b_p1), .p2(b_p2), .busy(b_busy), .done(b_done), .sym_idx(b_sym)
    );

    seq_generator_moore #(.LEN(LEN), .PULSE_CYC(2), .GAP_CYC(0)) dut_c (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern),
`ifdef SEQGEN_LOOP_EN
        .loop(loop_in),
`endif
        .p1(c_p1), .p2(c_p2), .busy(c_busy), .done(c_done), .sym_idx(c_sym)
    );

    assign obs[0] = {a_p1, a_p2, a_busy, a_done, a_sym};
    assign obs[1] = {b_p1, b_p2, b_busy, b_done, b_sym};
    assign obs[2] = {c_p1, c_p2, c_busy, c_done, c_sym};

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got={p1,p2,busy,done,sym}=%b want=%b", tag, got, want);
        end
    endtask

    // Expected outputs t cycles after the launching edge, from slot arithmetic alone.
    function automatic logic [6:0] model_out(input int p_cyc, input int g_cyc,
                                             input logic [3:0] pv, input int t);
        int   span;
        int   run;
        int   slot;
        logic b;
        span = p_cyc + g_cyc;
        run  = LEN * span;
        if (t < run) begin
            slot = t / span;
            b    = pv[LEN-1-slot];
            if ((t % span) < p_cyc) return {b, ~b, 2'b10, 3'(slot)};
            return {2'b00, 2'b10, 3'(slot)};
        end
        if (t == run) return {4'b0001, 3'(LEN)};
        return 7'b0;
    endfunction

    task automatic step();
        logic [6:0] want;
        logic [6:0] got;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                act[i] = 0;
            end else begin
                if (act[i] != 0 && (cyc - t0[i]) > LEN * (pc[i] + gc[i]) + 1) act[i] = 0;
                if (act[i] == 0 && start) begin
                    act[i] = 1;
                    t0[i]  = cyc;
                    pat[i] = pattern;
                end
            end
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            want = (act[i] != 0) ? model_out(pc[i], gc[i], pat[i], cyc - t0[i]) : 7'b0;
            got  = obs[i];
            if (reset && want[4:3] == 2'b00) got[2:0] = 3'b000;
            chk($sformatf("dut%0d_cyc%0d", i, cyc), got, want);
        end
    endtask

    initial begin
        pc[0] = 1; gc[0] = 1;
        pc[1] = 1; gc[1] = 0;
        pc[2] = 2; gc[2] = 0;
        for (int i = 0; i < 3; i++) begin
            act[i] = 0; t0[i] = 0; pat[i] = 4'h0;
        end
        reset   = 1'b0;
        start   = 1'b0;
        pattern = 4'h0;

        repeat (2) step();
        #2 reset = 1'b1;
        repeat (3) step();

        // Single 1001 run; pattern and start are disturbed while busy.
        start = 1'b1; pattern = 4'b1001;
        step();
        start = 1'b0; pattern = 4'b0110;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();

        // Start held high with an all-ones pattern: back-to-back runs one IDLE apart.
        start = 1'b1; pattern = 4'b1111;
        repeat (40) step();
        start = 1'b0;
        repeat (12) step();

        // Asynchronous reset in the middle of the first pulse.
        start = 1'b1; pattern = 4'(($urandom_range(0, 15)));
        step();
        start = 1'b0;
        #3 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("async_rst_dut%0d", i), obs[i], 7'b0);
        step();
        #2 reset = 1'b1;
        repeat (6) step();

        // Randomized start/pattern traffic.
        for (int n = 0; n < 400; n++) begin
            start   = ($urandom_range(0, 3) == 0);
            pattern = 4'($urandom_range(0, 15));
            step();
        end
        start = 1'b0;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
